// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: iterative unsigned shift-add multiplier that borrows an
// external ALU (add mode) for one add per multiplier bit and returns the full
// 2*size-bit product over a valid/ready response channel.
module alu_mul_sequencer #(
  parameter int         size    = 32,
  parameter logic [2:0] SEL_ADD = 3'b000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [size-1:0] req_a,
  input  logic [size-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [size-1:0] rsp_hi,
  output logic [size-1:0] rsp_lo,
  output logic            busy,
  output logic [size-1:0] alu_a,
  output logic [size-1:0] alu_b,
  output logic [2:0]      alu_sel,
  input  logic [size-1:0] alu_s,
  input  logic            alu_c
);

  localparam int CW = $clog2(size) + 1;
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [size-1:0]   mcand;
  logic [size-1:0]   acc;
  logic [size-1:0]   mplr;
  logic [CW-1:0]     cnt;

  // Control FSM plus shift-add datapath; handshake flags are registered
  // alongside the state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      mplr      <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mcand     <= req_a;
            mplr      <= req_b;
            acc       <= '0;
            cnt       <= '0;
            state     <= RUN;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          // The ALU carry becomes the new top bit of acc, so nothing is lost
          // on the right shift; the sum's LSB drops into the product low half.
          acc  <= {alu_c, alu_s[size-1:1]};
          mplr <= {alu_s[0], mplr[size-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // ALU operands: only driven during RUN so the shared ALU sees zeros otherwise.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    if (state == RUN) begin
      alu_a = acc;
      alu_b = mplr[0] ? mcand : '0;
    end
  end

  assign alu_sel = SEL_ADD;
  assign rsp_hi  = acc;
  assign rsp_lo  = mplr;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU, directed corner products,
// backpressure, held second request, mid-run reset and random operand pairs
// checked against a plain 64-bit multiply.
module tb_alu_mul_sequencer;

  localparam int         N       = 32;
  localparam logic [2:0] SEL_ADD = 3'b000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [N-1:0]  req_a = '0;
  logic [N-1:0]  req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [N-1:0]  rsp_hi;
  logic [N-1:0]  rsp_lo;
  logic          busy;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [2:0]    alu_sel;
  logic [N-1:0]  alu_s;
  logic          alu_c;
  logic [N:0]    alu_sum;

  int checks = 0;
  int errors = 0;

  alu_mul_sequencer #(.size(N), .SEL_ADD(SEL_ADD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_s(alu_s), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  // External ALU in add mode
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_s   = alu_sum[N-1:0];
  assign alu_c   = alu_sum[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rsp"}, {rsp_hi, rsp_lo}, 64'd0);
    chk({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
  endtask

  // Present a request at a negedge and return just after the accepting edge.
  task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (req_ready !== 1'b1) chk("accept_timeout", {63'd0, req_ready}, 64'd1);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Follow an accepted request through RUN and DONE, stall the response
  // for 'hold' cycles, then complete the handshake.
  task automatic finish(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
    logic [63:0] exp;
    logic [63:0] held;
    exp = 64'(a) * 64'(b);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("run_rsp_valid", rsp_valid, 1'b0);
      chk("run_req_ready", req_ready, 1'b0);
      chk("run_busy", busy, 1'b1);
      chk("run_alu_sel", alu_sel, SEL_ADD);
      chk("run_alu_b", (alu_b === '0 || alu_b === a), 1'b1);
    end
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, 1'b1);
    chk("product", {rsp_hi, rsp_lo}, exp);
    chk("done_req_ready", req_ready, 1'b0);
    chk("done_busy", busy, 1'b1);
    chk("done_alu_ab", {alu_a, alu_b}, 64'd0);
    held = {rsp_hi, rsp_lo};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_data", {rsp_hi, rsp_lo}, held);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_req_ready", req_ready, 1'b1);
    chk("post_rsp_valid", rsp_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
  endtask

  function automatic logic [N-1:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return N'(1) << $urandom_range(0, N - 1);
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    // Reset state
    #1 reset = 1'b1;
    #1 check_idle_reset_outputs("reset");
    chk("reset_alu_sel", alu_sel, SEL_ADD);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed products
    accept(32'd3, 32'd5);
    finish(32'd3, 32'd5, 0);
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    accept(32'h8000_0000, 32'd2);
    finish(32'h8000_0000, 32'd2, 0);
    accept(32'd0, 32'hDEAD_BEEF);
    finish(32'd0, 32'hDEAD_BEEF, 0);

    // Backpressure for 10 cycles in DONE
    accept(32'h1357_9BDF, 32'h0246_8ACE);
    finish(32'h1357_9BDF, 32'h0246_8ACE, 10);

    // Second request held on req_valid during RUN
    accept(32'h0000_00FF, 32'h0000_0101);
    req_a     = 32'h1234;
    req_b     = 32'h10;
    req_valid = 1'b1;
    finish(32'h0000_00FF, 32'h0000_0101, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    finish(32'h1234, 32'h10, 0);

    // Reset during RUN discards the product
    accept(32'hCAFE_F00D, 32'h1234_5678);
    repeat (12) @(negedge clk);
    #1 reset = 1'b1;
    #1 check_idle_reset_outputs("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("after_reset_rsp_valid", rsp_valid, 1'b0);
      chk("after_reset_req_ready", req_ready, 1'b1);
    end
    accept(32'd7, 32'd6);
    finish(32'd7, 32'd6, 0);

    // Random operand pairs against the reference product
    for (int k = 0; k < 1000; k++) begin
      ra = pick_operand();
      rb = pick_operand();
      accept(ra, rb);
      finish(ra, rb, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
